scan_chain_driver: RTL
======================

Name: scan_chain_driver

Overview:
- Host-side master for the microcontroller scan chain: drives scan_enable and the chain's scan_in, and captures the chain's scan_out.
- Loads a full program/state image one byte at a time and returns the previous chain contents byte for byte in the same pass.
- Sits beside the accumulator microcontroller and gates its proc_en so the core never runs while the chain is shifting.

Parameters:
- CHAIN_LEN, 280, total scan-chain length in bits (control unit + PC + IR + ACC + 32x8 memory); must be >= 1.
- NBYTES, ceil(CHAIN_LEN/8), derived localparam: bytes per pass.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a scan pass; sampled only in IDLE.
- run  in  1  host run request.
- in_data  in  8  next image byte to shift in.
- in_valid  in  1  in_data valid.
- in_ready  out  1  driver accepts in_data this cycle.
- out_data  out  8  captured byte from chain.
- out_valid  out  1  out_data valid.
- out_ready  in  1  host accepts out_data.
- chain_scan_out  in  1  serial output of the chain (the core's scan_out).
- chain_halt  in  1  core halt status.
- scan_enable  out  1  to core scan_enable.
- chain_scan_in  out  1  to core scan_in.
- proc_en  out  1  to core proc_en.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of pass.
- halted  out  1  registered copy of chain_halt.

Behaviour:
- Reset (rst==0 at clk edge): state IDLE, byte/bit counters 0, scan_enable 0, chain_scan_in 0, in_ready 0, out_valid 0, out_data 0, done 0, busy 0, halted 0. Reset mid-pass aborts immediately; chain contents are left partially shifted and are not restored.
- States: IDLE, LOAD, SHIFT, EMIT, DONE.
- IDLE:
  - proc_en = run (combinational AND with state==IDLE). proc_en is 0 in every other state.
  - start==1 -> LOAD, byte counter 0.
- LOAD:
  - in_ready=1.
  - On in_valid && in_ready: latch in_data into the shift buffer and go to SHIFT.
  - nbits = 8, except the last byte, where nbits = CHAIN_LEN mod 8 (8 if remainder 0).
- SHIFT:
  - scan_enable=1 for exactly nbits consecutive cycles.
  - Each cycle, chain_scan_in = buffer bit k, for k = 0..nbits-1 (LSB first). In the same cycle, chain_scan_out is sampled into capture bit k.
  - Capture bits >= nbits are 0.
  - After the last shift cycle: scan_enable=0 and go to EMIT.
- EMIT:
  - out_valid=1 with out_data = captured byte; scan_enable=0; in_ready=0.
  - On out_ready: if bytes remain, go to LOAD with byte counter incremented; otherwise go to DONE.
  - Backpressure holds EMIT indefinitely while the chain stays frozen.
- DONE: done=1 for one cycle, then IDLE.
- Bit ordering:
  - Bit 0 of byte 0 is the first bit shifted in; after a full pass it sits at the chain_scan_out end.
  - Capture bit 0 of byte 0 is the bit originally at the chain_scan_out end.
  - Consequence: a full pass followed by a second full pass reads back the first image exactly.
- Gaps between bytes: scan_enable stays low and proc_en stays low, so the chain holds its contents.
- start is ignored while busy. in_valid is ignored outside LOAD.
- chain_scan_in outside SHIFT is 0.
- halted is chain_halt registered every cycle.

Test Plan:
- CHAIN_LEN=12, 12-bit loopback chain model preloaded 0xABC (bit0 at output end); start; feed 0xA5, 0x03 -> chain_scan_in sequence 1,0,1,0,0,1,0,1 then 1,1,0,0; scan_enable high 8 cycles then 4; out bytes 0xBC, 0x0A; done pulses once.
- Second pass on the same model feeding 0x00, 0x00 -> out bytes 0xA5, 0x03 (readback of previous image); model ends at 0x000.
- Backpressure: hold out_ready=0 for 10 cycles after first byte -> out_valid stays 1, out_data stable 0xBC, scan_enable 0, in_ready 0; release -> pass completes with unchanged results.
- rst=0 at 5th shift cycle of first byte -> next cycle scan_enable 0, busy 0, in_ready 0, out_valid 0; new start then runs a clean full pass.
- proc_en gating: run=1 in IDLE -> proc_en 1; start -> proc_en 0 from the LOAD cycle until the cycle after done; start pulsed mid-pass has no effect.
- CHAIN_LEN=16 (remainder 0): two bytes, each with exactly 8 shift cycles; no partial-byte masking applied.

Source files
------------

// File: rtl/scan_chain_driver.sv
// Host-side scan-chain master: shifts an image into the core's scan chain byte by byte
// while returning the previous chain contents, and keeps the core stopped during a pass.
`timescale 1ns/1ps

module scan_chain_driver #(
    parameter int CHAIN_LEN = 280
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       chain_scan_out,
    input  logic       chain_halt,
    output logic       scan_enable,
    output logic       chain_scan_in,
    output logic       proc_en,
    output logic       busy,
    output logic       done,
    output logic       halted
);

    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [3:0] LAST_BITS = (CHAIN_LEN % 8 == 0) ? 4'd8 : 4'(CHAIN_LEN % 8);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, EMIT, DONE} state_t;

    state_t        state;
    logic [BW-1:0] byte_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_next;
    logic [7:0]    buffer;
    logic [7:0]    capture;
    logic [7:0]    capture_next;
    logic [3:0]    nbits;
    logic          last_byte;
    logic          last_bit;

    always_comb begin
        last_byte    = (byte_cnt == BW'(NBYTES - 1));
        nbits        = last_byte ? LAST_BITS : 4'd8;
        last_bit     = ({1'b0, bit_cnt} == nbits - 4'd1);
        bit_next     = bit_cnt + 3'd1;
        capture_next = capture;
        capture_next[bit_cnt] = chain_scan_out;
    end

    // The core may only run while the driver is idle; no register delay so gating is immediate.
    assign proc_en = run && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            bit_cnt       <= '0;
            scan_enable   <= 1'b0;
            chain_scan_in <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            // NOTE: buffer and capture are left unreset; both are fully written on entry to SHIFT before use.
        end else begin
            halted <= chain_halt;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= LOAD;
                    byte_cnt <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                end
                LOAD: if (in_valid) begin
                    buffer        <= in_data;
                    capture       <= '0;
                    bit_cnt       <= '0;
                    chain_scan_in <= in_data[0];
                    scan_enable   <= 1'b1;
                    in_ready      <= 1'b0;
                    state         <= SHIFT;
                end
                SHIFT: begin
                    capture <= capture_next;
                    if (last_bit) begin
                        scan_enable   <= 1'b0;
                        chain_scan_in <= 1'b0;
                        out_data      <= capture_next;
                        out_valid     <= 1'b1;
                        state         <= EMIT;
                    end else begin
                        bit_cnt       <= bit_next;
                        chain_scan_in <= buffer[bit_next];
                    end
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last_byte) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        byte_cnt <= byte_cnt + BW'(1);
                        in_ready <= 1'b1;
                        state    <= LOAD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
